modn_counter_prog: RTL
======================

# modn_counter_prog

Runtime-programmable modulo-N up/down counter: the parametrised successor to the fixed mod-N counter. It adds configurable width, a runtime modulus with shadowed (glitch-free) updates, direction control, enable, synchronous clear, parallel load, a terminal-count flag, a registered wrap pulse and a sticky error flag. It is used as a timebase/divider and as a cascadable counter stage in the team's sequential-logic library.

## Interface
- WIDTH, 4, counter width in bits; WIDTH >= 1.
- N_RESET, 6, modulus applied at reset; legal range 2..2^WIDTH.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; one clock domain.
- clr  input  1  synchronous clear.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- mod_n  input  WIDTH+1  requested modulus.
- mod_wr  input  1  strobe that captures mod_n into the pending register.
- q  output  WIDTH  count value; always < M.
- mod_q  output  WIDTH+1  active modulus M.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle wrap pulse.
- err  output  1  sticky error flag.

## Operation
- Reset (rst_n low, asynchronous) sets:
  - q = 0, M = N_RESET, pending = N_RESET, pend_vld = 0, wrap = 0, err = 0.
- Per-edge priority is clr > load > en; mod_wr is handled independently in the same cycle.
- clr: q <= 0. If pend_vld, M <= pending and pend_vld <= 0. wrap <= 0.
- load: if pend_vld, the pending modulus is applied first, giving M'; otherwise M' = M.
  - q <= load_val if load_val < M'.
  - Otherwise q <= M'-1 and err <= 1.
  - wrap <= 0.
- en, up = 1: q <= (q == M-1) ? 0 : q+1.
- en, up = 0: q <= (q == 0) ? M-1 : q-1.
- An enabled step that wraps sets wrap <= 1. If pend_vld, M <= pending, pend_vld <= 0, and the wrap target uses the new M (down-wrap lands on new M-1).
- Idle (no clr, load or en): q holds, wrap <= 0.
- mod_wr with 2 <= mod_n <= 2^WIDTH: pending <= mod_n, pend_vld <= 1. A later mod_wr before application overwrites pending.
- mod_wr with an out-of-range mod_n: ignored, err <= 1.
- Same-edge mod_wr and application: application uses the old pending value; the new value becomes pending with pend_vld = 1.
- Comparisons use a WIDTH+1-bit datapath, so M = 2^WIDTH is exact with no overflow.
- tc = en & ~clr & ~load & (up ? q == M-1 : q == 0).
- err is cleared only by reset.

## Timing
- q, mod_q, wrap and err change only on the rising clk edge, or asynchronously on rst_n falling.
- tc is combinational from en, clr, load, up, q and M.
- tc is asserted in the cycle before the wrapping edge; wrap is asserted in the cycle after it. This gives 1-cycle latency from tc to wrap.
- wrap lasts exactly one cycle per wrap. At M = 2 with en held, wrap is high every other cycle.
- A new modulus takes effect on the first clr, load or wrap edge after mod_wr; q never observes a value >= M.
- rst_n asserted mid-count forces the reset values immediately. Release is synchronous to the next rising edge; the first count happens on the first edge with rst_n high.

## Test plan
- WIDTH=4, N_RESET=6, en=1, up=1 from reset: q = 0,1,2,3,4,5,0,... tc is high when q=5, and wrap is high the cycle q returns to 0.
- up=0 from q=0: q = 5,4,3,2,1,0,5. tc is high at q=0; wrap follows each 0->5 transition.
- mod_wr with mod_n=3 while q=2, M=6: q continues 3,4,5, then wraps to 0 with mod_q=3. The sequence after that is 0,1,2,0.
- mod_wr with mod_n=1, then mod_n=17: both are ignored, M stays 6, err=1 and stays 1 until rst_n is asserted.
- load=1, load_val=9 with M=6: q=5 and err=1. Same edge clr=1 instead: q=0 (clr wins).
- rst_n low at q=4 mid-cycle: q=0, mod_q=6, wrap=0 and err=0 immediately. After release, counting resumes 1,2,... from the next edge with en=1.

Source files
------------

// File: rtl/modn_counter_prog_if.sv
// Bus bundle for modn_counter_prog.
// master: drives the control/config inputs and observes the count outputs.
// slave : the counter itself.
//   clr, en, up, load, load_val, mod_n, mod_wr : controls toward the counter
//   q, mod_q, tc, wrap, err                    : status from the counter
interface modn_counter_prog_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             clr;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   mod_n;
  logic             mod_wr;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   mod_q;
  logic             tc;
  logic             wrap;
  logic             err;

  modport master (
    output clr, en, up, load, load_val, mod_n, mod_wr,
    input  q, mod_q, tc, wrap, err
  );

  modport slave (
    input  clr, en, up, load, load_val, mod_n, mod_wr,
    output q, mod_q, tc, wrap, err
  );
endinterface

// File: rtl/modn_counter_prog.sv
// Runtime-programmable modulo-M up/down counter.
// A new modulus written via mod_wr is held pending and only becomes active on a
// clr, load or wrap edge, so q never sees a value outside the active range.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of modn_counter_prog_if (controls in, q/mod_q/tc/wrap/err out)
module modn_counter_prog #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned N_RESET = 6
) (
  input logic                clk,
  input logic                rst_n,
  modn_counter_prog_if.slave bus
);

  localparam logic [WIDTH:0] One    = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] ModMin = (WIDTH+1)'(2);
  localparam logic [WIDTH:0] ModMax = One << WIDTH;
  localparam logic [WIDTH:0] ModRst = (WIDTH+1)'(N_RESET);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   m_last;
  logic [WIDTH:0]   m_next;
  logic             at_top;
  logic             at_bot;
  logic             mod_ok;
  logic             apply;

  // Comparisons are WIDTH+1 bits wide so M = 2^WIDTH needs no special case.
  assign q_ext  = {1'b0, q_q};
  assign m_last = m_q - One;
  // Modulus in force after this edge if a pending value gets applied.
  assign m_next = pend_vld_q ? pend_q : m_q;
  assign at_top = (q_ext == m_last);
  assign at_bot = (q_q == '0);
  assign mod_ok = (bus.mod_n >= ModMin) && (bus.mod_n <= ModMax);

  always_comb begin
    q_d        = q_q;
    m_d        = m_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    wrap_d     = 1'b0;
    err_d      = err_q;
    apply      = 1'b0;

    if (bus.clr) begin
      q_d   = '0;
      apply = 1'b1;
    end else if (bus.load) begin
      apply = 1'b1;
      if ({1'b0, bus.load_val} < m_next) begin
        q_d = bus.load_val;
      end else begin
        q_d   = WIDTH'(m_next - One);
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_top) begin
          q_d    = '0;
          wrap_d = 1'b1;
          apply  = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          // Down-wrap lands on the top of the newly applied modulus.
          q_d    = WIDTH'(m_next - One);
          wrap_d = 1'b1;
          apply  = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end

    if (apply) begin
      m_d        = m_next;
      pend_vld_d = 1'b0;
    end

    // Evaluated after application: a same-edge write becomes the next pending value.
    if (bus.mod_wr) begin
      if (mod_ok) begin
        pend_d     = bus.mod_n;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      m_q        <= ModRst;
      pend_q     <= ModRst;
      pend_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      q_q        <= q_d;
      m_q        <= m_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.mod_q = m_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
  assign bus.tc    = bus.en & ~bus.clr & ~bus.load & (bus.up ? at_top : at_bot);

endmodule
